// File: rtl/demux12_8bit_stream_pkg.sv
// Shared constants, select encodings and slot state type for the 1:2 stream demultiplexer.
// The optional per-channel word counters are enabled with the DEMUX_CNT_EN macro.
package demux_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux12_8bit_stream_if.sv
// Producer-side and consumer-side stream signals of the demultiplexer.
// CNT_A/CNT_B exist only when DEMUX_CNT_EN is defined.
interface demux12_8bit_stream_if #(
    parameter int WIDTH = demux_pkg::DATA_W
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = demux_pkg::CNT_W
`endif
) ();

    logic [WIDTH-1:0] D;
    logic             S;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] YA;
    logic             YA_VALID;
    logic             YA_READY;
    logic [WIDTH-1:0] YB;
    logic             YB_VALID;
    logic             YB_READY;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] CNT_A;
    logic [CNT_W-1:0] CNT_B;
`endif

    // The demultiplexer itself.
    modport slave (
        input  D, S, IN_VALID, YA_READY, YB_READY,
        output IN_READY, YA, YA_VALID, YB, YB_VALID
`ifdef DEMUX_CNT_EN
        , output CNT_A, CNT_B
`endif
    );

    // The producer and the two consumers around it.
    modport master (
        output D, S, IN_VALID, YA_READY, YB_READY,
        input  IN_READY, YA, YA_VALID, YB, YB_VALID
`ifdef DEMUX_CNT_EN
        , input CNT_A, CNT_B
`endif
    );

endinterface

// File: rtl/demux12_8bit_stream_slot.sv
// One-entry output slot: holding register, EMPTY/FULL state and optional delivery counter.
// The counter is built only when DEMUX_CNT_EN is defined.
module demux_slot #(
    parameter int WIDTH = demux_pkg::DATA_W
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = demux_pkg::CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             can_accept
`ifdef DEMUX_CNT_EN
    , output logic [CNT_W-1:0] cnt
`endif
);
    import demux_pkg::*;

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             handshake;

    assign handshake  = (state_q == FULL) && y_ready;
    // A FULL slot can take a new word only in the cycle its current word leaves.
    assign can_accept = (state_q == EMPTY) || y_ready;

    // NOTE: every always_comb output gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            data_d  = din;
        end else if (handshake) begin
            state_d = EMPTY;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign y       = data_q;
    assign y_valid = (state_q == FULL);

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (handshake) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux12_8bit_stream.sv
// Registered 1:2 valid/ready stream demultiplexer: S steers each accepted word to slot A or B.
// Define DEMUX_CNT_EN to add the CNT_A/CNT_B delivered-word counters.
module demux12_8bit_stream #(
    parameter int WIDTH = demux_pkg::DATA_W
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = demux_pkg::CNT_W
`endif
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    demux12_8bit_stream_if.slave  bus
);
    import demux_pkg::*;

    logic sel_b;
    logic can_accept_a, can_accept_b;
    logic in_ready;
    logic load_a, load_b;

    assign sel_b = (bus.S == SEL_B);

    // Only the selected slot gates the input; the other channel never stalls the producer.
    always_comb begin
        in_ready = 1'b0;
        if (RST_N) begin
            in_ready = sel_b ? can_accept_b : can_accept_a;
        end
    end

    assign load_a       = bus.IN_VALID && in_ready && !sel_b;
    assign load_b       = bus.IN_VALID && in_ready &&  sel_b;
    assign bus.IN_READY = in_ready;

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) u_slot_a (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load       (load_a),
        .din        (bus.D),
        .y          (bus.YA),
        .y_valid    (bus.YA_VALID),
        .y_ready    (bus.YA_READY),
        .can_accept (can_accept_a)
`ifdef DEMUX_CNT_EN
        , .cnt      (bus.CNT_A)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) u_slot_b (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load       (load_b),
        .din        (bus.D),
        .y          (bus.YB),
        .y_valid    (bus.YB_VALID),
        .y_ready    (bus.YB_READY),
        .can_accept (can_accept_b)
`ifdef DEMUX_CNT_EN
        , .cnt      (bus.CNT_B)
`endif
    );

endmodule

// File: doc/demux12_8bit_stream.md
# demux12_8bit_stream

Registered 1:2 stream demultiplexer, the inverse of the team's 2:1 8-bit mux. It takes one valid/ready byte stream plus a select bit and steers each accepted word into one of two output channels, A or B. Each channel has a one-entry holding register, so the two channels drain independently. It sits between a shared producer and two consumers.

## Interface
Parameters:
- WIDTH, default 8: data width of D, YA and YB.
- CNT_W, default 16: width of the per-channel word counters. Used only with DEMUX_CNT_EN.

Ports:
- CLK, input, 1: the single clock; all state changes on its rising edge.
- RST_N, input, 1: synchronous, active-low reset, sampled on the rising edge of CLK.
- D, input, WIDTH: input data word.
- S, input, 1: channel select. 0 routes to A, 1 routes to B. Sampled with D.
- IN_VALID, input, 1: D and S are valid.
- IN_READY, output, 1: the block can accept the word this cycle.
- YA, output, WIDTH: channel A data.
- YA_VALID, output, 1: YA holds a word.
- YA_READY, input, 1: the A consumer takes the word.
- YB, output, WIDTH: channel B data.
- YB_VALID, output, 1: YB holds a word.
- YB_READY, input, 1: the B consumer takes the word.
- CNT_A, output, CNT_W: count of words delivered on A. Present only with DEMUX_CNT_EN.
- CNT_B, output, CNT_W: count of words delivered on B. Present only with DEMUX_CNT_EN.

## Operation
- Each channel slot is a two-state FSM with states EMPTY and FULL.
  - EMPTY to FULL: an input word is accepted for this channel.
  - FULL to EMPTY: the output handshake completes (Yx_VALID and Yx_READY) and no new word is accepted for this channel in the same cycle.
  - FULL stays FULL in two cases: no output handshake occurs, or an output handshake and a new acceptance occur in the same cycle. In the second case the slot reloads with the new word.
- Input acceptance is IN_VALID and IN_READY.
- IN_READY is combinational:
  - It is 0 while RST_N is low.
  - Otherwise it equals (selected slot EMPTY) or (selected slot FULL and its Yx_READY is 1).
  - IN_READY depends on S and the selected channel's Yx_READY only. The other channel has no effect on it.
- When a word is accepted, D is loaded into the selected slot's data register.
- The unselected slot is untouched. It may drain, or stay FULL, in the same cycle.
- Yx holds the last loaded word and does not change when the slot empties. Consumers must qualify Yx with Yx_VALID.
- Word order within each channel is preserved. Across the two channels no ordering is guaranteed.
- No word is dropped and no word is duplicated.
- Yx_VALID and Yx come straight from registers, with no combinational path from input to output.

## Timing
- Reset values:
  - YA = 0, YB = 0.
  - YA_VALID = 0, YB_VALID = 0.
  - Both slots in state EMPTY.
  - CNT_A = 0, CNT_B = 0.
- Reset in mid-operation: buffered words are discarded at the next rising edge of CLK with RST_N low. No handshake completes in that cycle.
- Latency: a word accepted in cycle n appears as Yx_VALID = 1 in cycle n+1.
- Throughput: one word per cycle on one channel when its consumer holds Yx_READY = 1, including back-to-back words to the same channel.
- Switching S every cycle also sustains one word per cycle while both consumers are ready.
- Back-pressure: when the selected slot is FULL and Yx_READY = 0, IN_READY = 0. The producer must hold D, S and IN_VALID stable until the word is accepted.
- A Yx_READY asserted while Yx_VALID = 0 has no effect.

## Configuration
- DEMUX_CNT_EN defined:
  - CNT_A and CNT_B exist as ports.
  - Each counter increments by 1 on its channel's output handshake.
  - Each counter wraps from 2^CNT_W−1 to 0.
  - Both counters clear on reset.
- DEMUX_CNT_EN undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package demux_pkg holds:
  - the default constants DATA_W = 8 and CNT_W = 16;
  - the select encodings SEL_A = 1'b0 and SEL_B = 1'b1, matching the mux convention;
  - the slot state enum {EMPTY, FULL}.
- One sub-module, demux_slot:
  - contents: one holding register plus its FSM, and the optional counter;
  - ports: load, data in, Yx, Yx_VALID, Yx_READY, and a can_accept output;
  - it is instantiated twice.
- The top level decodes S, builds IN_READY and drives each slot's load signal.

## Test plan
- Reset: hold RST_N = 0 for 2 cycles with IN_VALID = 1, D = 8'hFF. Required: IN_READY = 0, YA = YB = 8'h00, both valids 0; no word appears after release.
- Basic routing: send D = 8'h81, S = 0, then D = 8'h49, S = 1, with both readies at 1. Required: YA = 8'h81 with YA_VALID in the cycle after the first accept; YB = 8'h49 one cycle later; each valid drops after its handshake.
- Back-pressure: YA_READY = 0, stream 8'h11, 8'h22 with S = 0. Required: 8'h11 held on YA, IN_READY = 0 while the second word waits. Raise YA_READY: 8'h22 is accepted in the same cycle as the 8'h11 handshake, and YA shows 8'h22 on the next cycle.
- Channel independence: keep A FULL with YA_READY = 0, then send 8'h98 with S = 1. Required: IN_READY = 1, YB = 8'h98 while YA still holds its word.
- Reset mid-operation: with both slots FULL, pulse RST_N low for one cycle. Required: both valids 0 on the next cycle, no word delivered, and normal operation resumes afterwards.
- Counters (DEMUX_CNT_EN, CNT_W = 4): deliver 17 words on A and 3 on B. Required: CNT_A = 1 (wrapped), CNT_B = 3. With the macro undefined, the same bench minus the counter checks passes.
